// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared constants and FSM encoding for the data-memory responder
package data_mem_responder_pkg;

  localparam int CNT_W = 4;
  localparam logic [7:0] IO_ADDR_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_responder_wait_counter.sv
// rtl/data_mem_responder_wait_counter.sv - loadable down-counter timing the wait states
module wait_counter
  import data_mem_responder_pkg::*;
(
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated register RAM plus io_out register answering core load/store requests
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter int                DEPTH       = 128,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(IO_ADDR_DEFAULT)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [DATA_W-1:0] io_out
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] io_out_q, io_out_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              cnt_last;
  logic              capture;
  logic              enter_resp;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              hit_ram;
  logic              hit_io;
  logic [IDX_W-1:0]  ram_idx;

  assign capture = (state_q == ST_IDLE) && req;

  wait_counter u_wait_counter (
    .clock    (clock),
    .rst      (rst),
    .load     (capture),
    .load_val (CNT_W'(WAIT_CYCLES)),
    .dec      (state_q == ST_WAIT),
    .last     (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_last) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the capture edge, so decode the live inputs then.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      cur_we    = we;
      cur_addr  = addr;
      cur_wdata = wdata;
    end
  end

  assign hit_ram    = (32'(cur_addr) < DEPTH);
  assign hit_io     = !hit_ram && (cur_addr == IO_ADDR);
  assign ram_idx    = cur_addr[IDX_W-1:0];
  assign enter_resp = (state_d == ST_RESP);

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (capture) begin
      we_d    = we;
      addr_d  = addr;
      wdata_d = wdata;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    io_out_d = io_out_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    if (enter_resp) begin
      ready_d = 1'b1;
      err_d   = !(hit_ram || hit_io);
      if (cur_we) begin
        if (hit_ram) begin
          mem_d[ram_idx] = cur_wdata;
        end else if (hit_io) begin
          io_out_d = cur_wdata;
        end
      end else begin
        if (hit_ram) begin
          rdata_d = mem_q[ram_idx];
        end else if (hit_io) begin
          rdata_d = io_out_q;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      io_out_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      io_out_q <= io_out_d;
      mem_q    <= mem_d;
    end
  end

  assign ready  = ready_q;
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign io_out = io_out_q;
  assign busy   = (state_q != ST_IDLE);

endmodule
